median_rank_3x3_stream: RTL and testbench

- Next-generation 3x3 neighbourhood filter for the image pipeline.
- Accepts a raw row-major frame of exactly W*H pixels over a valid/ready stream. It generates the extra right column and bottom row flush cycles internally, so upstream does not pad.
- Output is a selectable rank statistic (min/median/max/any rank 0..8) with replicate or constant border, on a backpressurable stream.
- Frame size is set at run time up to MAX_WIDTH x MAX_HEIGHT.

---
 rtl/median_rank_3x3_stream_pkg.sv | 22 ++
 rtl/median_rank_3x3_stream_if.sv | 20 ++
 rtl/median_rank_3x3_stream_sortnet.sv | 34 +++
 rtl/median_rank_3x3_stream.sv | 176 +++++++++++++++++
 tb/tb_median_rank_3x3_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_rank_3x3_stream_pkg.sv
// Shared constants and types for the 3x3 rank filter.
// Rank selectors, border modes and FSM encodings.
package median_pkg;

  localparam logic [3:0] RANK_MIN = 4'd0;
  localparam logic [3:0] RANK_MED = 4'd4;
  localparam logic [3:0] RANK_MAX = 4'd8;

  localparam logic BORDER_REPLICATE = 1'b0;
  localparam logic BORDER_CONST     = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/median_rank_3x3_stream_if.sv
// Pixel stream bundle: data plus position and frame markers.
// A beat transfers on a rising clk edge where valid && ready. Once valid is raised by
// the master, all payload fields stay stable until that transfer.
interface median_rank_3x3_stream_if #(
  parameter int DW = 8,
  parameter int XW = 11,
  parameter int YW = 11
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          sof;
  logic          eol;
  logic          eof;

  modport master (output valid, data, x, y, sof, eol, eof, input ready);
  modport slave  (input valid, data, x, y, sof, eol, eof, output ready);
endinterface

// File: rtl/median_rank_3x3_stream_sortnet.sv
// Nine-input compare-exchange sorter (odd-even transposition) returning one rank.
// Ranks above 8 select the maximum.
module rank9_sortnet
  import median_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [8:0][DW-1:0] taps,
  input  logic [3:0]         rank,
  output logic [DW-1:0]      value
);

  logic [DW-1:0] v [9];
  logic [DW-1:0] t;
  logic [3:0]    sel;

  always_comb begin
    for (int i = 0; i < 9; i++) v[i] = taps[i];
    t = '0;
    // nine alternating passes fully sort nine values
    for (int p = 0; p < 9; p++) begin
      for (int i = p % 2; i < 8; i += 2) begin
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
      end
    end
    sel   = (rank > RANK_MAX) ? RANK_MAX : rank;
    value = v[sel];
  end

endmodule

// File: rtl/median_rank_3x3_stream.sv
// Streaming 3x3 rank filter over a raw WxH frame; the extra right column and bottom
// row steps are generated internally so the output stays aligned with the centre pixel.
module median_rank_3x3_stream
  import median_pkg::*;
#(
  parameter int DW         = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int MAX_HEIGHT = 1024,
  parameter int XW         = $clog2(MAX_WIDTH + 1),
  parameter int YW         = $clog2(MAX_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] cfg_width,
  input  logic [YW-1:0] cfg_height,
  input  logic [3:0]    cfg_rank,
  input  logic          cfg_border,
  input  logic [DW-1:0] cfg_const,
  median_rank_3x3_stream_if.slave  s,
  median_rank_3x3_stream_if.master m,
  output logic          busy,
  output logic          cfg_err,
  output state_e        dbg_state
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic [1:0]    state;
  logic          run_en;
  logic [XW-1:0] ix, w_q, w_eff;
  logic [YW-1:0] iy, h_q, h_eff;
  logic [3:0]    rank_q;
  logic          border_q;
  logic [DW-1:0] const_q;

  logic [DW-1:0] lb0 [MAX_WIDTH];
  logic [DW-1:0] lb1 [MAX_WIDTH];
  logic [DW-1:0] c0 [3];
  logic [DW-1:0] c1 [3];
  logic [DW-1:0] new_col [3];
  logic [DW-1:0] lb0_rd, lb1_rd;
  logic [AW-1:0] lb_addr;

  logic cfg_legal, real_step, slot_free, can_step, step_go, emit, last_step;
  logic edge_l, edge_r, edge_t, edge_b;
  logic [8:0][DW-1:0] grid;
  logic [DW-1:0]      rank_out;

  assign cfg_legal = (cfg_width != '0) && (cfg_width <= XW'(MAX_WIDTH)) &&
                     (cfg_height != '0) && (cfg_height <= YW'(MAX_HEIGHT));

  // The live config only matters for the very first step; afterwards the latched size rules.
  assign w_eff = (state == ST_IDLE) ? cfg_width  : w_q;
  assign h_eff = (state == ST_IDLE) ? cfg_height : h_q;

  assign real_step = (ix < w_eff) && (iy < h_eff);
  assign slot_free = !m.valid || m.ready;
  assign can_step  = (state == ST_RUN) || ((state == ST_IDLE) && cfg_legal);
  assign s.ready   = run_en && slot_free && can_step && real_step;
  assign step_go   = run_en && slot_free && can_step && (!real_step || s.valid);
  assign emit      = step_go && (ix != '0) && (iy != '0);
  assign last_step = (ix == w_eff) && (iy == h_eff);

  assign edge_l = (ix == XW'(1));
  assign edge_r = (ix == w_eff);
  assign edge_t = (iy == YW'(1));
  assign edge_b = (iy == h_eff);

  assign lb_addr    = ix[AW-1:0];
  assign lb0_rd     = lb0[lb_addr];
  assign lb1_rd     = lb1[lb_addr];
  assign new_col[0] = lb1_rd;
  assign new_col[1] = lb0_rd;
  assign new_col[2] = s.data;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state_e'(state);

  // Columns are clamped first, then rows copy the clamped middle row, giving per-tap corners.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      grid[r*3+0] = edge_l ? c0[r] : c1[r];
      grid[r*3+1] = c0[r];
      grid[r*3+2] = edge_r ? c0[r] : new_col[r];
    end
    for (int c = 0; c < 3; c++) begin
      if (edge_t) grid[c]   = grid[3+c];
      if (edge_b) grid[6+c] = grid[3+c];
    end
    if (border_q == BORDER_CONST) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if ((r == 0 && edge_t) || (r == 2 && edge_b) ||
              (c == 0 && edge_l) || (c == 2 && edge_r))
            grid[r*3+c] = const_q;
        end
      end
    end
  end

  rank9_sortnet #(.DW(DW)) u_sortnet (
    .taps  (grid),
    .rank  (rank_q),
    .value (rank_out)
  );

  always_ff @(posedge clk) begin
    if (step_go) begin
      c1         <= c0;
      c0[0]      <= lb1_rd;
      c0[1]      <= lb0_rd;
      c0[2]      <= s.data;
      if (ix < w_eff) begin
        lb1[lb_addr] <= lb0_rd;
        lb0[lb_addr] <= s.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      run_en   <= 1'b0;
      ix       <= '0;
      iy       <= '0;
      w_q      <= '0;
      h_q      <= '0;
      rank_q   <= '0;
      border_q <= 1'b0;
      const_q  <= '0;
      cfg_err  <= 1'b0;
      m.valid  <= 1'b0;
      m.data   <= '0;
      m.x      <= '0;
      m.y      <= '0;
      m.sof    <= 1'b0;
      m.eol    <= 1'b0;
      m.eof    <= 1'b0;
    end else begin
      run_en <= 1'b1;
      if (state == ST_IDLE && run_en && !cfg_legal) cfg_err <= 1'b1;
      if (m.valid && m.ready) m.valid <= 1'b0;
      if (step_go) begin
        if (state == ST_IDLE) begin
          w_q      <= cfg_width;
          h_q      <= cfg_height;
          rank_q   <= cfg_rank;
          border_q <= cfg_border;
          const_q  <= cfg_const;
          state    <= ST_RUN;
        end
        if (last_step) begin
          ix    <= '0;
          iy    <= '0;
          state <= ST_DRAIN;
        end else if (ix == w_eff) begin
          ix <= '0;
          iy <= iy + YW'(1);
        end else begin
          ix <= ix + XW'(1);
        end
        if (emit) begin
          m.valid <= 1'b1;
          m.data  <= rank_out;
          m.x     <= ix - XW'(1);
          m.y     <= iy - YW'(1);
          m.sof   <= edge_l && edge_t;
          m.eol   <= edge_r;
          m.eof   <= last_step;
        end
      end
      if (state == ST_DRAIN && m.valid && m.ready && m.eof) state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_median_rank_3x3_stream.sv
// Bench for median_rank_3x3_stream: scenario tasks feed frames, a queue of expected
// beats is filled from a clamped-coordinate reference and drained by the output monitor.
module tb_median_rank_3x3_stream;
  import median_pkg::*;

  localparam int DW   = 8;
  localparam int MAXW = 32;
  localparam int MAXH = 32;
  localparam int XW   = $clog2(MAXW + 1);
  localparam int YW   = $clog2(MAXH + 1);
  localparam int EW   = DW + XW + YW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_height;
  logic [3:0]    cfg_rank;
  logic          cfg_border;
  logic [DW-1:0] cfg_const;
  logic          busy, cfg_err;
  state_e        dbg_state;

  median_rank_3x3_stream_if #(.DW(DW), .XW(XW), .YW(YW)) s_if ();
  median_rank_3x3_stream_if #(.DW(DW), .XW(XW), .YW(YW)) m_if ();

  median_rank_3x3_stream #(.DW(DW), .MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_rank   (cfg_rank),
    .cfg_border (cfg_border),
    .cfg_const  (cfg_const),
    .s          (s_if),
    .m          (m_if),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_pct = 100;
  int eof_cyc = -1;
  int eof_hs_cyc = -1;
  logic [DW-1:0] frame [0:MAXW*MAXH-1];
  logic [EW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.ready = ($urandom_range(99) < ready_pct);
    end
  end

  function automatic logic [DW-1:0] model_px(input int w, input int h, input int cx, input int cy,
                                             input int rank, input logic border, input logic [DW-1:0] cval);
    logic [DW-1:0] t [9];
    logic [DW-1:0] tmp;
    int n, x, y, sel;
    n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        x = cx + dx;
        y = cy + dy;
        if (border && (x < 0 || x >= w || y < 0 || y >= h)) t[n] = cval;
        else begin
          if (x < 0) x = 0;
          if (x >= w) x = w - 1;
          if (y < 0) y = 0;
          if (y >= h) y = h - 1;
          t[n] = frame[y*w + x];
        end
        n++;
      end
    end
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (t[j-1] > t[j]) begin
          tmp = t[j-1]; t[j-1] = t[j]; t[j] = tmp;
        end
      end
    end
    sel = (rank > 8) ? 8 : rank;
    return t[sel];
  endfunction

  task automatic push_expected(input int w, input int h, input int rank, input logic border,
                               input logic [DW-1:0] cval);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        exp_q.push_back({model_px(w, h, x, y, rank, border, cval), XW'(x), YW'(y),
                         (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)});
      end
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int rank, input logic border,
                         input logic [DW-1:0] cval);
    cfg_width = XW'(w); cfg_height = YW'(h); cfg_rank = 4'(rank);
    cfg_border = border; cfg_const = cval;
  endtask

  task automatic send_frame(input int w, input int h, input int vpct, output int acc_cyc);
    int i, guard;
    bit fire;
    i = 0; guard = 0; acc_cyc = -1;
    @(posedge clk); #1;
    while (i < w * h && guard < 20000) begin
      s_if.valid = ($urandom_range(99) < vpct);
      s_if.data  = frame[i];
      @(negedge clk);
      fire = s_if.valid && s_if.ready;
      if (fire && acc_cyc < 0) acc_cyc = cyc;
      @(posedge clk); #1;
      if (fire) i++;
      guard++;
    end
    s_if.valid = 1'b0;
    checks++;
    if (i != w * h) begin
      failures++;
      $display("FAIL send_frame accepted=%0d required=%0d", i, w * h);
    end
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", tag, exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after got=%b exp=0", tag, busy);
    end
  endtask

  // Output monitor: scoreboard pops on each handshake, and stalled beats must hold.
  logic [EW:0] held;
  bit          stalled = 0;
  always @(negedge clk) begin
    logic [EW-1:0] got, want;
    if (!rst_n) stalled = 0;
    else begin
      got = {m_if.data, m_if.x, m_if.y, m_if.sof, m_if.eol, m_if.eof};
      if (stalled) begin
        checks++;
        if ({m_if.valid, got} !== held) begin
          failures++;
          $display("FAIL stall_hold got=%h exp=%h", {m_if.valid, got}, held);
        end
      end
      if (m_if.valid && m_if.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got=%h exp=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL beat got=%h exp=%h (data,x,y,sof,eol,eof)", got, want);
          end
        end
        if (m_if.eof && eof_hs_cyc < 0) eof_hs_cyc = cyc;
      end
      if (m_if.valid && m_if.eof && eof_cyc < 0) eof_cyc = cyc;
      stalled = m_if.valid && !m_if.ready;
      held    = {m_if.valid, got};
    end
  end

  task automatic load_ramp(input int w, input int h);
    for (int i = 0; i < w * h; i++) frame[i] = DW'(i);
  endtask

  task automatic test_reset;
    set_cfg(4, 3, 4, 1'b0, 8'h00);
    s_if.valid = 1'b0; s_if.data = '0; s_if.x = '0; s_if.y = '0;
    s_if.sof = 1'b0; s_if.eol = 1'b0; s_if.eof = 1'b0;
    #12;
    checks++;
    if ({m_if.valid, s_if.ready, busy, cfg_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {m_if.valid, s_if.ready, busy, cfg_err});
    end
    checks++;
    if ({m_if.data, m_if.x, m_if.y, m_if.sof, m_if.eol, m_if.eof} !== '0) begin
      failures++;
      $display("FAIL reset_payload got=%h exp=0", {m_if.data, m_if.x, m_if.y});
    end
    #11 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_if.ready !== 1'b1 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_release got=%b/%0d exp=1/0", s_if.ready, dbg_state);
    end
  endtask

  task automatic test_ramp_median;
    int acc;
    load_ramp(4, 3);
    set_cfg(4, 3, 4, 1'b0, 8'h00);
    eof_cyc = -1;
    push_expected(4, 3, 4, 1'b0, 8'h00);
    send_frame(4, 3, 100, acc);
    wait_empty("ramp");
    checks++;
    if (eof_cyc - acc !== 20) begin
      failures++;
      $display("FAIL ramp_latency got=%0d exp=20", eof_cyc - acc);
    end
  endtask

  task automatic test_const_border;
    int acc;
    int ranks [3] = '{0, 8, 4};
    load_ramp(4, 3);
    for (int k = 0; k < 3; k++) begin
      set_cfg(4, 3, ranks[k], 1'b1, 8'd255);
      push_expected(4, 3, ranks[k], 1'b1, 8'd255);
      send_frame(4, 3, 100, acc);
      wait_empty("const");
    end
  endtask

  task automatic test_random;
    int acc;
    ready_pct = 50;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) frame[i] = DW'($urandom_range(255));
      if (k == 0) set_cfg(16, 16, 4, 1'b0, 8'h00);
      else        set_cfg(16, 16, 12, 1'b1, DW'($urandom_range(255)));
      push_expected(16, 16, int'(cfg_rank), cfg_border, cfg_const);
      send_frame(16, 16, 50, acc);
      wait_empty("random");
    end
    ready_pct = 100;
  endtask

  task automatic test_single_pixel;
    int acc;
    frame[0] = 8'h37;
    set_cfg(1, 1, 4, 1'b0, 8'h00);
    exp_q.push_back({8'h37, XW'(0), YW'(0), 3'b111});
    send_frame(1, 1, 100, acc);
    wait_empty("single");
    cfg_width = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || s_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL bad_cfg got=%b%b exp=10", cfg_err, s_if.ready);
    end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2;
    for (int i = 0; i < 32; i++) frame[i] = DW'($urandom_range(255));
    set_cfg(8, 4, 4, 1'b0, 8'h10);
    push_expected(8, 4, 4, 1'b0, 8'h10);
    eof_hs_cyc = -1;
    fork
      send_frame(8, 4, 100, acc1);
      begin
        repeat (10) @(posedge clk); #1;
        set_cfg(3, 5, 0, 1'b1, 8'h10);
      end
    join
    for (int i = 0; i < 15; i++) frame[i] = DW'($urandom_range(255));
    push_expected(3, 5, 0, 1'b1, 8'h10);
    send_frame(3, 5, 100, acc2);
    wait_empty("b2b");
    checks++;
    if (eof_hs_cyc < 0 || acc2 <= eof_hs_cyc) begin
      failures++;
      $display("FAIL b2b_order got_accept=%0d exp_after=%0d", acc2, eof_hs_cyc);
    end
  endtask

  task automatic test_reset_mid_frame;
    int acc;
    for (int i = 0; i < 32; i++) frame[i] = DW'($urandom_range(255));
    set_cfg(8, 4, 4, 1'b0, 8'h00);
    @(posedge clk); #1;
    s_if.valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.data = frame[i];
      @(posedge clk); #1;
    end
    s_if.valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({m_if.valid, s_if.ready, busy, cfg_err, m_if.data} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b%b%b/%h exp=0000/00", m_if.valid, s_if.ready, busy,
               cfg_err, m_if.data);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_ramp(4, 3);
    set_cfg(4, 3, 4, 1'b0, 8'h00);
    push_expected(4, 3, 4, 1'b0, 8'h00);
    send_frame(4, 3, 100, acc);
    wait_empty("post_reset");
  endtask

  initial begin
    test_reset();
    test_ramp_median();
    test_const_border();
    test_random();
    test_single_pixel();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
